debug_data_serializer: RTL and testbench

Debug-path producer that sits directly downstream of the MicroBlaze debug interface's `o_request_select` output and feeds its `i_frame_from_mips` / `i_eod` inputs. On a one-cycle request it snapshots the selected MIPS source and streams it back as consecutive 32-bit words, MSB-first, one per cycle. Sources are a register-file entry, the PC, one data- or instruction-memory word, or a pipeline latch group. After the last word it marks end-of-data for one cycle.

---
 rtl/debug_pkg.sv | 45 ++++
 rtl/debug_data_serializer.sv | 154 +++++++++++++++
 tb/tb_debug_data_serializer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared request-select codes, FSM state type and word-count LUT for the debug data path.
// Used by the serializer and by the interface-side models that must agree on stream length.
package debug_pkg;

    localparam int NB_FRAME = 32;

    localparam logic [5:0] SEL_MEM_DATA       = 6'h20;
    localparam logic [5:0] SEL_MEM_INSTR      = 6'h21;
    localparam logic [5:0] SEL_PC             = 6'h22;
    localparam logic [5:0] SEL_FETCH_DATA     = 6'h24;
    localparam logic [5:0] SEL_FETCH_CTRL     = 6'h25;
    localparam logic [5:0] SEL_DECO_DATA      = 6'h26;
    localparam logic [5:0] SEL_DECO_CTRL      = 6'h27;
    localparam logic [5:0] SEL_EXEC_DATA      = 6'h28;
    localparam logic [5:0] SEL_EXEC_CTRL      = 6'h29;
    localparam logic [5:0] SEL_MEM_LATCH_DATA = 6'h2A;
    localparam logic [5:0] SEL_MEM_LATCH_CTRL = 6'h2B;
    localparam logic [5:0] IDLE_SEL           = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_EOD
    } state_e;

    // Codes 0x00..0x1F address the register file; every unlisted code streams nothing.
    function automatic logic [1:0] word_count(input logic [5:0] sel);
        logic [1:0] n;
        n = 2'd0;
        if (!sel[5]) begin
            n = 2'd1;
        end else begin
            case (sel)
                SEL_MEM_DATA, SEL_MEM_INSTR, SEL_PC:          n = 2'd1;
                SEL_FETCH_DATA, SEL_MEM_LATCH_DATA:           n = 2'd2;
                SEL_DECO_DATA, SEL_EXEC_DATA:                 n = 2'd3;
                SEL_FETCH_CTRL, SEL_DECO_CTRL,
                SEL_EXEC_CTRL, SEL_MEM_LATCH_CTRL:            n = 2'd1;
                default:                                      n = 2'd0;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/debug_data_serializer.sv
// Snapshots a selected MIPS debug source on a one-cycle request and streams it MSB-first, one word per cycle, then a one-cycle EOD.
// Word k appears in cycle 1+k, EOD in cycle 1+N; no backpressure, requests while busy are dropped.
module debug_data_serializer #(
    parameter int NB_FRAME      = debug_pkg::NB_FRAME,
    parameter int NB_BUFFER     = 96,
    parameter int NB_ADDR_DATA  = 16,
    parameter int NB_INSTR_ADDR = 9
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [5:0]               i_request_select,
    input  logic [NB_ADDR_DATA-1:0]  i_mem_addr,
    output logic [4:0]               o_reg_addr,
    input  logic [31:0]              i_reg_data,
    input  logic [31:0]              i_pc,
    output logic [NB_ADDR_DATA-1:0]  o_dmem_addr,
    input  logic [31:0]              i_dmem_data,
    output logic [NB_INSTR_ADDR-1:0] o_imem_addr,
    input  logic [31:0]              i_imem_data,
    input  logic [NB_BUFFER-1:0]     i_latch_fetch_data,
    input  logic [NB_BUFFER-1:0]     i_latch_fetch_ctrl,
    input  logic [NB_BUFFER-1:0]     i_latch_deco_data,
    input  logic [NB_BUFFER-1:0]     i_latch_deco_ctrl,
    input  logic [NB_BUFFER-1:0]     i_latch_exec_data,
    input  logic [NB_BUFFER-1:0]     i_latch_exec_ctrl,
    input  logic [NB_BUFFER-1:0]     i_latch_mem_data,
    input  logic [NB_BUFFER-1:0]     i_latch_mem_ctrl,
    output logic [NB_FRAME-1:0]      o_frame,
    output logic                     o_eod,
    output logic                     o_busy
);
    import debug_pkg::*;

    state_e                   state_q, state_d;
    logic [5:0]               sel_q, sel_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [NB_BUFFER-1:0]     buf_q, buf_d;
    logic [4:0]               reg_addr_q, reg_addr_d;
    logic [NB_ADDR_DATA-1:0]  dmem_addr_q, dmem_addr_d;
    logic [NB_INSTR_ADDR-1:0] imem_addr_q, imem_addr_d;

    logic                     req;
    logic [1:0]               req_cnt;
    logic [NB_BUFFER-1:0]     snap;

    assign req     = (i_request_select != IDLE_SEL);
    assign req_cnt = word_count(i_request_select);

    // Single-word sources land in the top word so they leave through the same tap as latch data.
    always_comb begin
        snap = '0;
        if (!i_request_select[5]) begin
            snap = {i_reg_data, {(NB_BUFFER-32){1'b0}}};
        end else begin
            case (i_request_select)
                SEL_PC:             snap = {i_pc, {(NB_BUFFER-32){1'b0}}};
                SEL_FETCH_DATA:     snap = i_latch_fetch_data;
                SEL_FETCH_CTRL:     snap = i_latch_fetch_ctrl;
                SEL_DECO_DATA:      snap = i_latch_deco_data;
                SEL_DECO_CTRL:      snap = i_latch_deco_ctrl;
                SEL_EXEC_DATA:      snap = i_latch_exec_data;
                SEL_EXEC_CTRL:      snap = i_latch_exec_ctrl;
                SEL_MEM_LATCH_DATA: snap = i_latch_mem_data;
                SEL_MEM_LATCH_CTRL: snap = i_latch_mem_ctrl;
                default:            snap = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        reg_addr_d  = reg_addr_q;
        dmem_addr_d = dmem_addr_q;
        imem_addr_d = imem_addr_q;
        o_reg_addr  = reg_addr_q;
        o_dmem_addr = dmem_addr_q;
        o_imem_addr = imem_addr_q;
        o_frame     = '0;
        o_eod       = 1'b0;
        o_busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    sel_d   = i_request_select;
                    cnt_d   = req_cnt;
                    buf_d   = snap;
                    state_d = (req_cnt == 2'd0) ? ST_EOD : ST_SEND;
                    // Addresses go out in the request cycle so the sync RAMs return data in cycle 1.
                    if (!i_request_select[5]) begin
                        o_reg_addr = i_request_select[4:0];
                        reg_addr_d = i_request_select[4:0];
                    end
                    if (i_request_select == SEL_MEM_DATA) begin
                        o_dmem_addr = i_mem_addr;
                        dmem_addr_d = i_mem_addr;
                    end
                    if (i_request_select == SEL_MEM_INSTR) begin
                        o_imem_addr = i_mem_addr[NB_INSTR_ADDR-1:0];
                        imem_addr_d = i_mem_addr[NB_INSTR_ADDR-1:0];
                    end
                end
            end
            ST_SEND: begin
                o_busy = 1'b1;
                if (sel_q == SEL_MEM_DATA) begin
                    o_frame = i_dmem_data;
                end else if (sel_q == SEL_MEM_INSTR) begin
                    o_frame = i_imem_data;
                end else begin
                    o_frame = buf_q[NB_BUFFER-1 -: NB_FRAME];
                end
                buf_d = buf_q << NB_FRAME;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = ST_EOD;
                end
            end
            ST_EOD: begin
                o_busy  = 1'b1;
                o_eod   = 1'b1;
                cnt_d   = 2'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= IDLE_SEL;
            cnt_q       <= '0;
            buf_q       <= '0;
            reg_addr_q  <= '0;
            dmem_addr_q <= '0;
            imem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            reg_addr_q  <= reg_addr_d;
            dmem_addr_q <= dmem_addr_d;
            imem_addr_q <= imem_addr_d;
        end
    end

endmodule

// File: tb/tb_debug_data_serializer.sv
// Self-checking bench: directed scenarios plus randomized requests against a queue-based reference model.
module tb_debug_data_serializer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [5:0]  i_request_select;
    logic [15:0] i_mem_addr;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic [31:0] i_pc;
    logic [15:0] o_dmem_addr;
    logic [31:0] i_dmem_data;
    logic [8:0]  o_imem_addr;
    logic [31:0] i_imem_data;
    logic [95:0] lat_fd, lat_fc, lat_dd, lat_dc, lat_ed, lat_ec, lat_md, lat_mc;
    logic [31:0] o_frame;
    logic        o_eod;
    logic        o_busy;

    logic [31:0] regfile [32];
    logic [31:0] dmem    [256];
    logic [31:0] imem    [512];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign i_reg_data = regfile[o_reg_addr];

    always @(posedge clk) begin
        i_dmem_data <= dmem[o_dmem_addr[7:0]];
        i_imem_data <= imem[o_imem_addr];
    end

    debug_data_serializer dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_request_select   (i_request_select),
        .i_mem_addr         (i_mem_addr),
        .o_reg_addr         (o_reg_addr),
        .i_reg_data         (i_reg_data),
        .i_pc               (i_pc),
        .o_dmem_addr        (o_dmem_addr),
        .i_dmem_data        (i_dmem_data),
        .o_imem_addr        (o_imem_addr),
        .i_imem_data        (i_imem_data),
        .i_latch_fetch_data (lat_fd),
        .i_latch_fetch_ctrl (lat_fc),
        .i_latch_deco_data  (lat_dd),
        .i_latch_deco_ctrl  (lat_dc),
        .i_latch_exec_data  (lat_ed),
        .i_latch_exec_ctrl  (lat_ec),
        .i_latch_mem_data   (lat_md),
        .i_latch_mem_ctrl   (lat_mc),
        .o_frame            (o_frame),
        .o_eod              (o_eod),
        .o_busy             (o_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_count(input logic [5:0] sel);
        if (sel < 6'h20) return 1;
        case (sel)
            6'h20, 6'h21, 6'h22: return 1;
            6'h24: return 2;
            6'h25: return 1;
            6'h26: return 3;
            6'h27: return 1;
            6'h28: return 3;
            6'h29: return 1;
            6'h2A: return 2;
            6'h2B: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [95:0] latch_of(input logic [5:0] sel);
        case (sel)
            6'h24: return lat_fd;
            6'h25: return lat_fc;
            6'h26: return lat_dd;
            6'h27: return lat_dc;
            6'h28: return lat_ed;
            6'h29: return lat_ec;
            6'h2A: return lat_md;
            6'h2B: return lat_mc;
            default: return '0;
        endcase
    endfunction

    task automatic scramble_sources();
        lat_fd = {$urandom, $urandom, $urandom};
        lat_fc = {$urandom, $urandom, $urandom};
        lat_dd = {$urandom, $urandom, $urandom};
        lat_dc = {$urandom, $urandom, $urandom};
        lat_ed = {$urandom, $urandom, $urandom};
        lat_ec = {$urandom, $urandom, $urandom};
        lat_md = {$urandom, $urandom, $urandom};
        lat_mc = {$urandom, $urandom, $urandom};
        i_pc   = $urandom;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_request_select = 6'h3F;
        i_mem_addr = '0;
        #3 i_reset = 1'b0;
        #1;
        total++; if (o_frame !== 32'h0) $display("FAIL reset_frame: got %h want 0", o_frame); else passed++;
        total++; if (o_eod !== 1'b0) $display("FAIL reset_eod: got %b want 0", o_eod); else passed++;
        total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else passed++;
        total++; if (o_reg_addr !== 5'h0) $display("FAIL reset_reg_addr: got %h want 0", o_reg_addr); else passed++;
        total++; if (o_dmem_addr !== 16'h0) $display("FAIL reset_dmem_addr: got %h want 0", o_dmem_addr); else passed++;
        total++; if (o_imem_addr !== 9'h0) $display("FAIL reset_imem_addr: got %h want 0", o_imem_addr); else passed++;
        step();
        step();
        i_reset = 1'b1;
        step();
    endtask

    task automatic test_reg_read();
        regfile[5] = 32'hDEADBEEF;
        i_request_select = 6'h05;
        #1;
        total++; if (o_reg_addr !== 5'h05) $display("FAIL reg_addr_c0: got %h want 05", o_reg_addr); else passed++;
        step();
        i_request_select = 6'h3F;
        total++; if (o_frame !== 32'hDEADBEEF || o_eod !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL reg_word: got %h eod %b busy %b want DEADBEEF 0 1", o_frame, o_eod, o_busy); else passed++;
        step();
        total++; if (o_eod !== 1'b1 || o_frame !== 32'h0)
            $display("FAIL reg_eod: got eod %b frame %h want 1 0", o_eod, o_frame); else passed++;
        step();
        total++; if (o_busy !== 1'b0 || o_eod !== 1'b0)
            $display("FAIL reg_idle: got busy %b eod %b want 0 0", o_busy, o_eod); else passed++;
    endtask

    task automatic test_deco_snapshot();
        logic [31:0] want [3];
        want[0] = 32'h11111111; want[1] = 32'h22222222; want[2] = 32'h33333333;
        lat_dd = 96'h111111112222222233333333;
        i_request_select = 6'h26;
        step();
        i_request_select = 6'h3F;
        lat_dd = 96'hAAAAAAAABBBBBBBBCCCCCCCC;
        for (int k = 0; k < 3; k++) begin
            total++; if (o_frame !== want[k] || o_busy !== 1'b1 || o_eod !== 1'b0)
                $display("FAIL deco_word%0d: got %h busy %b eod %b want %h 1 0", k, o_frame, o_busy, o_eod, want[k]); else passed++;
            step();
        end
        total++; if (o_eod !== 1'b1 || o_frame !== 32'h0)
            $display("FAIL deco_eod: got eod %b frame %h want 1 0", o_eod, o_frame); else passed++;
        step();
        total++; if (o_busy !== 1'b0) $display("FAIL deco_idle: got busy %b want 0", o_busy); else passed++;
    endtask

    task automatic test_dmem();
        dmem[4] = 32'h0000ABCD;
        i_request_select = 6'h20;
        i_mem_addr = 16'h0004;
        #1;
        total++; if (o_dmem_addr !== 16'h0004) $display("FAIL dmem_addr_c0: got %h want 0004", o_dmem_addr); else passed++;
        step();
        i_request_select = 6'h3F;
        i_mem_addr = 16'h00FF;
        #1;
        total++; if (o_frame !== 32'h0000ABCD) $display("FAIL dmem_word: got %h want 0000ABCD", o_frame); else passed++;
        total++; if (o_dmem_addr !== 16'h0004) $display("FAIL dmem_addr_hold: got %h want 0004", o_dmem_addr); else passed++;
        step();
        total++; if (o_eod !== 1'b1) $display("FAIL dmem_eod: got %b want 1", o_eod); else passed++;
        step();
    endtask

    task automatic test_unmapped();
        i_request_select = 6'h30;
        #1;
        total++; if (o_busy !== 1'b0) $display("FAIL unmapped_busy_c0: got %b want 0", o_busy); else passed++;
        step();
        i_request_select = 6'h3F;
        total++; if (o_eod !== 1'b1 || o_busy !== 1'b1 || o_frame !== 32'h0)
            $display("FAIL unmapped_eod: got eod %b busy %b frame %h want 1 1 0", o_eod, o_busy, o_frame); else passed++;
        step();
        total++; if (o_busy !== 1'b0 || o_eod !== 1'b0)
            $display("FAIL unmapped_idle: got busy %b eod %b want 0 0", o_busy, o_eod); else passed++;
    endtask

    task automatic test_ignore_while_busy();
        logic [95:0] src;
        lat_ed = {$urandom, $urandom, $urandom};
        src = lat_ed;
        i_request_select = 6'h28;
        step();
        i_request_select = 6'h24;
        for (int k = 0; k < 3; k++) begin
            total++; if (o_frame !== src[95-32*k -: 32])
                $display("FAIL ignore_word%0d: got %h want %h", k, o_frame, src[95-32*k -: 32]); else passed++;
            step();
            i_request_select = 6'h3F;
        end
        total++; if (o_eod !== 1'b1) $display("FAIL ignore_eod: got %b want 1", o_eod); else passed++;
        step();
        step();
        total++; if (o_busy !== 1'b0 || o_eod !== 1'b0)
            $display("FAIL ignore_no_restart: got busy %b eod %b want 0 0", o_busy, o_eod); else passed++;
    endtask

    task automatic test_reset_mid_stream();
        logic [95:0] src;
        lat_dd = {$urandom, $urandom, $urandom};
        src = lat_dd;
        i_request_select = 6'h26;
        step();
        i_request_select = 6'h3F;
        total++; if (o_frame !== src[95:64]) $display("FAIL abort_word0: got %h want %h", o_frame, src[95:64]); else passed++;
        step();
        i_reset = 1'b0;
        #1;
        total++; if (o_frame !== 32'h0 || o_eod !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL abort_outputs: got frame %h eod %b busy %b want 0 0 0", o_frame, o_eod, o_busy); else passed++;
        step();
        total++; if (o_eod !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL abort_no_eod: got eod %b busy %b want 0 0", o_eod, o_busy); else passed++;
        i_reset = 1'b1;
        step();
        regfile[9] = 32'hCAFEF00D;
        i_request_select = 6'h09;
        step();
        i_request_select = 6'h3F;
        total++; if (o_frame !== 32'hCAFEF00D) $display("FAIL abort_recover_word: got %h want CAFEF00D", o_frame); else passed++;
        step();
        total++; if (o_eod !== 1'b1) $display("FAIL abort_recover_eod: got %b want 1", o_eod); else passed++;
        step();
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] exp_q [$];
        logic [95:0] src;
        logic [5:0]  sel;
        logic [15:0] addr;
        int          n;
        for (int it = 0; it < 40; it++) begin
            scramble_sources();
            sel  = 6'($urandom_range(0, 62));
            addr = 16'($urandom_range(0, 255));
            n    = exp_count(sel);
            exp_q.delete();
            src  = latch_of(sel);
            for (int k = 0; k < n; k++) begin
                if (sel < 6'h20)       exp_q.push_back(regfile[sel[4:0]]);
                else if (sel == 6'h20) exp_q.push_back(dmem[addr[7:0]]);
                else if (sel == 6'h21) exp_q.push_back(imem[addr[8:0]]);
                else if (sel == 6'h22) exp_q.push_back(i_pc);
                else                   exp_q.push_back(src[95-32*k -: 32]);
            end
            i_request_select = sel;
            i_mem_addr = addr;
            step();
            // Disturb every source and offer a spurious request; none of it may reach the stream.
            i_request_select = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 62)) : 6'h3F;
            i_mem_addr = 16'($urandom);
            scramble_sources();
            if (sel < 6'h20) regfile[sel[4:0]] = $urandom;
            for (int k = 0; k < n; k++) begin
                total++; if (o_frame !== exp_q[k] || o_busy !== 1'b1 || o_eod !== 1'b0)
                    $display("FAIL rand_word it%0d sel %h k%0d: got %h busy %b eod %b want %h 1 0",
                             it, sel, k, o_frame, o_busy, o_eod, exp_q[k]); else passed++;
                step();
                i_request_select = 6'h3F;
            end
            total++; if (o_eod !== 1'b1 || o_frame !== 32'h0 || o_busy !== 1'b1)
                $display("FAIL rand_eod it%0d sel %h: got eod %b frame %h busy %b want 1 0 1",
                         it, sel, o_eod, o_frame, o_busy); else passed++;
            step();
            i_request_select = 6'h3F;
            total++; if (o_busy !== 1'b0 || o_eod !== 1'b0)
                $display("FAIL rand_idle it%0d sel %h: got busy %b eod %b want 0 0", it, sel, o_busy, o_eod); else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++)  regfile[i] = $urandom;
        for (int i = 0; i < 256; i++) dmem[i]    = $urandom;
        for (int i = 0; i < 512; i++) imem[i]    = $urandom;
        scramble_sources();
        test_reset();
        test_reg_read();
        test_deco_snapshot();
        test_dmem();
        test_unmapped();
        test_ignore_while_busy();
        test_reset_mid_stream();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
